// File: rtl/addressable_channel_router.sv
`default_nettype none
// ---------------------------------------------------------------------------
// addressable_channel_router : host access -> one-hot channel strobes, rev 1.0
// ---------------------------------------------------------------------------
module addressable_channel_router #(
   parameter int                    ADDRESS_WIDTH  = 4,
   parameter int                    CHANNELS       = 4,
   parameter int                    BASE_ADDRESS   = 0,
   parameter logic [2*CHANNELS-1:0] DIRECTION_MASK = '1,
   parameter int                    TIMEOUT_CYCLES = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] active_address,
   input  logic                     read_enable_in,
   input  logic                     write_enable_in,
   input  logic                     req_valid,
   output logic                     req_ready,
   output logic [CHANNELS-1:0]      read_enable_out,
   output logic [CHANNELS-1:0]      write_enable_out,
   input  logic [CHANNELS-1:0]      channel_done,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [1:0]               resp_error
);

   localparam int IW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam int OW    = ADDRESS_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_PHASE = 2'd1,
      WR_PHASE = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t              state, state_n;
   logic [IW-1:0]       idx, idx_n;
   logic                wr_pending, wr_pending_n;
   logic [CW-1:0]       tcount, tcount_n;
   logic [CHANNELS-1:0] rd_en_n, wr_en_n;
   logic                resp_valid_n;
   logic [1:0]          resp_error_n;

   logic [OW-1:0]       offset;
   logic                in_range, rd_allowed, wr_allowed;
   logic [CHANNELS-1:0] req_onehot, cur_onehot;
   logic                done_sel, timeout_hit;

   assign req_ready = (state == IDLE) && !reset;

   // Offset is one bit wider than the address so the window test cannot wrap.
   assign offset   = OW'(active_address) - OW'(BASE_ADDRESS);
   assign in_range = (OW'(active_address) >= OW'(BASE_ADDRESS)) && (offset < OW'(CHANNELS));

   always_comb begin
      rd_allowed = 1'b0;
      wr_allowed = 1'b0;
      req_onehot = '0;
      cur_onehot = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (offset == OW'(k)) begin
            rd_allowed    = DIRECTION_MASK[2*k];
            wr_allowed    = DIRECTION_MASK[2*k+1];
            req_onehot[k] = 1'b1;
         end
         cur_onehot[k] = (idx == IW'(k));
      end
   end

   assign done_sel    = |(channel_done & cur_onehot);
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (tcount == CW'(LIMIT));

   always_comb begin
      state_n      = state;
      idx_n        = idx;
      wr_pending_n = wr_pending;
      tcount_n     = tcount;
      rd_en_n      = read_enable_out;
      wr_en_n      = write_enable_out;
      resp_valid_n = resp_valid;
      resp_error_n = resp_error;
      case (state)
         IDLE: begin
            if (req_valid) begin
               idx_n        = offset[IW-1:0];
               wr_pending_n = write_enable_in;
               tcount_n     = '0;
               if (!read_enable_in && !write_enable_in) begin
                  state_n      = RESP;
                  resp_valid_n = 1'b1;
                  resp_error_n = 2'd3;
               end else if (!in_range || (read_enable_in && !rd_allowed) ||
                            (write_enable_in && !wr_allowed)) begin
                  state_n      = RESP;
                  resp_valid_n = 1'b1;
                  resp_error_n = 2'd1;
               end else if (read_enable_in) begin
                  state_n = RD_PHASE;
                  rd_en_n = req_onehot;
               end else begin
                  state_n = WR_PHASE;
                  wr_en_n = req_onehot;
               end
            end
         end
         RD_PHASE: begin
            if (done_sel) begin
               rd_en_n  = '0;
               tcount_n = '0;
               if (wr_pending) begin
                  state_n = WR_PHASE;
                  wr_en_n = cur_onehot;
               end else begin
                  state_n      = RESP;
                  resp_valid_n = 1'b1;
                  resp_error_n = 2'd0;
               end
            end else if (timeout_hit) begin
               rd_en_n      = '0;
               state_n      = RESP;
               resp_valid_n = 1'b1;
               resp_error_n = 2'd2;
            end else begin
               tcount_n = tcount + CW'(1);
            end
         end
         WR_PHASE: begin
            if (done_sel || timeout_hit) begin
               wr_en_n      = '0;
               state_n      = RESP;
               resp_valid_n = 1'b1;
               resp_error_n = done_sel ? 2'd0 : 2'd2;
            end else begin
               tcount_n = tcount + CW'(1);
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_n      = IDLE;
               resp_valid_n = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         idx              <= '0;
         wr_pending       <= 1'b0;
         tcount           <= '0;
         read_enable_out  <= '0;
         write_enable_out <= '0;
         resp_valid       <= 1'b0;
         resp_error       <= 2'd0;
      end else begin
         state            <= state_n;
         idx              <= idx_n;
         wr_pending       <= wr_pending_n;
         tcount           <= tcount_n;
         read_enable_out  <= rd_en_n;
         write_enable_out <= wr_en_n;
         resp_valid       <= resp_valid_n;
         resp_error       <= resp_error_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_addressable_channel_router.sv
`default_nettype none
// Testbench for addressable_channel_router: directed table plus random ops
// checked against a phase-level model of the router's rules.
module tb_addressable_channel_router;

   localparam int              AW   = 4;
   localparam int              CH   = 4;
   localparam int              BASE = 4;
   localparam int              TO   = 3;
   localparam logic [2*CH-1:0] MASK = 8'h7F;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] active_address;
   logic          read_enable_in, write_enable_in, req_valid, req_ready;
   logic [CH-1:0] read_enable_out, write_enable_out, channel_done;
   logic          resp_valid, resp_ready;
   logic [1:0]    resp_error;

   always #5 clk = ~clk;

   addressable_channel_router #(
      .ADDRESS_WIDTH (AW),
      .CHANNELS      (CH),
      .BASE_ADDRESS  (BASE),
      .DIRECTION_MASK(MASK),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .active_address  (active_address),
      .read_enable_in  (read_enable_in),
      .write_enable_in (write_enable_in),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .read_enable_out (read_enable_out),
      .write_enable_out(write_enable_out),
      .channel_done    (channel_done),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_error      (resp_error)
   );

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int addr; bit rd; bit wr; int rd_d; int wr_d; int stall;
      int err;  int rc; int wc; int lat;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Done cycles are 1-based within a phase; 0 means done never arrives.
   function automatic void model(input int addr, input bit rd, input bit wr,
                                 input int rd_d, input int wr_d,
                                 output int err, output int rc, output int wc, output int lat);
      int ch;
      ch  = addr - BASE;
      err = 0; rc = 0; wc = 0;
      if (!rd && !wr) err = 3;
      else if (ch < 0 || ch >= CH) err = 1;
      else if ((rd && !MASK[2*ch]) || (wr && !MASK[2*ch+1])) err = 1;
      else begin
         if (rd) begin
            if (rd_d >= 1 && rd_d <= TO) rc = rd_d;
            else begin rc = TO; err = 2; end
         end
         if (wr && err == 0) begin
            if (wr_d >= 1 && wr_d <= TO) wc = wr_d;
            else begin wc = TO; err = 2; end
         end
      end
      lat = 1 + rc + wc;
   endfunction

   task automatic run_op(input int addr, input bit rd, input bit wr, input int rd_d,
                         input int wr_d, input int stall,
                         output int err, output int rc, output int wc, output int lat,
                         output int bad);
      int            cyc, ch;
      bit            got;
      logic [CH-1:0] sel;
      ch  = addr - BASE;
      sel = '0;
      if (ch >= 0 && ch < CH) sel[ch] = 1'b1;
      err = -1; rc = 0; wc = 0; lat = -1; bad = 0;
      @(negedge clk);
      check("req_ready_idle", int'(req_ready), 1);
      active_address  = AW'(addr);
      read_enable_in  = rd;
      write_enable_in = wr;
      req_valid       = 1'b1;
      @(negedge clk);
      req_valid      = 1'b0;
      active_address = AW'($urandom);
      cyc = 1;
      got = 1'b0;
      while (!got && cyc < 40) begin
         if (read_enable_out != '0 && write_enable_out != '0) bad = 1;
         if (read_enable_out != '0 && read_enable_out != sel) bad = 1;
         if (write_enable_out != '0 && write_enable_out != sel) bad = 1;
         channel_done = CH'($urandom) & ~sel;
         if (read_enable_out != '0) begin
            rc++;
            if (rc == rd_d) channel_done = channel_done | sel;
         end
         if (write_enable_out != '0) begin
            wc++;
            if (wc == wr_d) channel_done = channel_done | sel;
         end
         if (resp_valid) begin
            got = 1'b1;
            lat = cyc;
            err = int'(resp_error);
            for (int s = 0; s < stall; s++) begin
               resp_ready      = 1'b0;
               req_valid       = 1'b1;
               active_address  = AW'(BASE);
               read_enable_in  = 1'b1;
               write_enable_in = 1'b0;
               @(negedge clk);
               if (!resp_valid || int'(resp_error) != err || req_ready ||
                   read_enable_out != '0 || write_enable_out != '0) bad = 1;
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      resp_ready   = 1'b0;
      channel_done = '0;
      if (!got) begin
         n_vec++;
         n_bad++;
         $display("FAIL resp_wait: no resp_valid within %0d cycles, expected one", cyc);
      end else begin
         check("resp_release", int'(resp_valid) * 2 + int'(req_ready), 1);
      end
   endtask

   task automatic apply(input string tag, input vec_t v);
      int err, rc, wc, lat, bad;
      run_op(v.addr, v.rd, v.wr, v.rd_d, v.wr_d, v.stall, err, rc, wc, lat, bad);
      check({tag, "_err"}, err, v.err);
      check({tag, "_rd_cycles"}, rc, v.rc);
      check({tag, "_wr_cycles"}, wc, v.wc);
      check({tag, "_latency"}, lat, v.lat);
      check({tag, "_strobe_ok"}, bad, 0);
   endtask

   vec_t tbl[12];

   initial begin
      vec_t v;
      reset = 1'b1; active_address = '0; read_enable_in = 1'b0; write_enable_in = 1'b0;
      req_valid = 1'b0; resp_ready = 1'b0; channel_done = '0;

      tbl[0]  = '{6, 1, 0, 3, 0, 5, 0, 3, 0, 4};
      tbl[1]  = '{5, 1, 1, 1, 2, 0, 0, 1, 2, 4};
      tbl[2]  = '{8, 1, 0, 1, 0, 0, 1, 0, 0, 1};
      tbl[3]  = '{3, 0, 1, 0, 1, 0, 1, 0, 0, 1};
      tbl[4]  = '{7, 0, 1, 0, 1, 0, 1, 0, 0, 1};
      tbl[5]  = '{7, 1, 1, 1, 1, 0, 1, 0, 0, 1};
      tbl[6]  = '{4, 0, 0, 1, 1, 2, 3, 0, 0, 1};
      tbl[7]  = '{4, 1, 0, 0, 0, 0, 2, 3, 0, 4};
      tbl[8]  = '{4, 0, 1, 0, 3, 1, 0, 0, 3, 4};
      tbl[9]  = '{5, 1, 1, 0, 1, 0, 2, 3, 0, 4};
      tbl[10] = '{6, 1, 1, 2, 0, 0, 2, 2, 3, 6};
      tbl[11] = '{7, 1, 0, 1, 0, 0, 0, 1, 0, 2};

      repeat (3) @(negedge clk);
      check("reset_req_ready", int'(req_ready), 0);
      check("reset_enables", int'({read_enable_out, write_enable_out}), 0);
      check("reset_resp_valid", int'(resp_valid), 0);
      check("reset_resp_error", int'(resp_error), 0);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) apply($sformatf("tbl%0d", i), tbl[i]);

      for (int i = 0; i < 40; i++) begin
         v.addr  = $urandom_range(15, 0);
         v.rd    = 1'($urandom);
         v.wr    = 1'($urandom);
         v.rd_d  = $urandom_range(4, 0);
         v.wr_d  = $urandom_range(4, 0);
         v.stall = $urandom_range(2, 0);
         model(v.addr, v.rd, v.wr, v.rd_d, v.wr_d, v.err, v.rc, v.wc, v.lat);
         apply($sformatf("rnd%0d", i), v);
      end

      // Reset asserted during the write phase of a read-modify-write.
      @(negedge clk);
      active_address = AW'(5); read_enable_in = 1'b1; write_enable_in = 1'b1; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_rd_strobe", int'(read_enable_out), 2);
      channel_done = 4'b0010;
      @(negedge clk);
      channel_done = '0;
      check("rst_wr_strobe", int'(write_enable_out), 2);
      reset = 1'b1;
      @(negedge clk);
      check("rst_enables_low", int'({read_enable_out, write_enable_out}), 0);
      check("rst_no_resp", int'(resp_valid), 0);
      check("rst_req_ready_held", int'(req_ready), 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_req_ready_back", int'(req_ready), 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_quiet", int'({resp_valid, read_enable_out, write_enable_out}), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
